// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, fflags bit positions, binary32
// constants and the int2float FSM state type.
package fpu_pkg;

  localparam int XLEN     = 32;
  localparam int EXP_BIAS = 127;

  // fflags = {NV,DZ,OF,UF,NX}
  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } i2f_state_e;

endpackage

// File: rtl/int2float_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input counts as 32.
module lzc32 (
  input  logic [31:0] a,
  output logic [5:0]  cnt
);

  // Scan upward so the most significant set bit is the last to overwrite cnt.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) cnt = 6'(31 - i);
    end
  end

endmodule

// File: rtl/int2float.sv
// FCVT.S.W / FCVT.S.WU: three-step integer to binary32 conversion
// (capture, normalise, round) behind a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for an operand, in_ready=1
//   NORM  | leading-zero count, left-justify magnitude, form exponent
//   ROUND | apply rounding increment, write result and NX
//   HOLD  | result presented until out_ready; can accept the next operand
module int2float
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  input  logic        is_signed,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_NORM  = NORM;
  localparam logic [1:0] ST_ROUND = ROUND;
  localparam logic [1:0] ST_HOLD  = HOLD;

  logic [1:0]  state;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [2:0]  rm_q;
  logic [30:0] norm_q;   // left-justified magnitude without its implicit leading 1
  logic [7:0]  exp_q;
  logic        zero_q;

  logic        accept;
  logic        sign_in;
  logic [31:0] mag_in;
  logic [5:0]  lz;

  logic [22:0] man;
  logic        g_bit, r_bit, s_bit, inexact, inc;
  logic [30:0] rounded;

  assign in_ready = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign sign_in  = is_signed & int_in[31];
  // 0x80000000 negates to itself, which is already the correct magnitude.
  assign mag_in   = sign_in ? -int_in : int_in;

  lzc32 u_lzc (
    .a   (mag_q),
    .cnt (lz)
  );

  // Rounding increment and the single exponent+mantissa add; a mantissa
  // carry rolls naturally into the exponent field.
  always_comb begin
    man     = norm_q[30:8];
    g_bit   = norm_q[7];
    r_bit   = norm_q[6];
    s_bit   = |norm_q[5:0];
    inexact = g_bit | r_bit | s_bit;
    case (rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign_q & inexact;
      RM_RUP:  inc = ~sign_q & inexact;
      RM_RMM:  inc = g_bit;
      default: inc = g_bit & (r_bit | s_bit | man[0]);
    endcase
    rounded = {exp_q, man} + {30'd0, inc};
  end

  // Operand capture from IDLE or back-to-back from HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      rm_q   <= '0;
    end else if (accept) begin
      sign_q <= sign_in;
      mag_q  <= mag_in;
      rm_q   <= rm;
    end
  end

  // Control FSM plus the normalise and result registers it sequences.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      norm_q    <= '0;
      exp_q     <= '0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      fflags    <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_NORM;
        end
        ST_NORM: begin
          norm_q <= 31'(mag_q << lz);
          exp_q  <= 8'(EXP_BIAS + 31 - int'(lz));
          zero_q <= (mag_q == '0);
          state  <= ST_ROUND;
        end
        ST_ROUND: begin
          if (zero_q) begin
            result <= '0;
            fflags <= '0;
          end else begin
            result           <= {sign_q, rounded};
            fflags           <= '0;
            fflags[FFLAG_NX] <= inexact;
          end
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? ST_NORM : ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
